csr_timer: RTL and testbench

CSR-mapped periodic timer that sits directly downstream of the CSR access path. It is driven by the same decoded CSR access signals (en, op, rs1, in) as any individual CSR and returns the pre-access configuration value on `old`. The written configuration sets a prescaler and a compare value. The block counts prescaled ticks and raises a one-cycle `interrupt` pulse towards the interrupt controller on each compare match.

---
 rtl/decoder_pkg.sv | 17 +
 rtl/timer_pkg.sv | 25 ++
 rtl/csr.sv | 47 ++++
 rtl/csr_timer.sv | 103 ++++++++++
 tb/tb_csr_timer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/decoder_pkg.sv
// Decoder-side types shared by every CSR: operand word, immediate source and CSR opcode.
package decoder_pkg;

    typedef logic [31:0] word;
    typedef logic [4:0]  r;

    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSRRW    = 3'b001,
        CSRRS    = 3'b010,
        CSRRC    = 3'b011,
        CSRRWI   = 3'b101,
        CSRRSI   = 3'b110,
        CSRRCI   = 3'b111
    } csr_t;

endpackage

// File: rtl/timer_pkg.sv
// Shared definitions for csr_timer: config field layout and the write-event decode.
package timer_pkg;

    localparam int unsigned PrescalerBitsDefault = 4;
    localparam int unsigned PrescalerLsb         = 0;
    localparam int unsigned CompareLsb           = PrescalerBitsDefault;

    typedef struct packed {
        logic [31-PrescalerBitsDefault:0] compare;
        logic [PrescalerBitsDefault-1:0]  prescaler;
    } timer_cfg_t;

    // Set/clear with an all-zero mask is a pure read and must not restart the timer.
    function automatic logic is_csr_write(input decoder_pkg::csr_t op,
                                          input decoder_pkg::word in,
                                          input decoder_pkg::r rs1);
        case (op)
            decoder_pkg::CSRRW, decoder_pkg::CSRRWI: return 1'b1;
            decoder_pkg::CSRRS, decoder_pkg::CSRRC:  return in != '0;
            decoder_pkg::CSRRSI, decoder_pkg::CSRRCI: return rs1 != '0;
            default:                                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/csr.sv
// Generic CSR storage: applies the Zicsr read-modify-write ops and returns the pre-access value.
module csr
    import decoder_pkg::*;
#(
    parameter word DefaultValue = '0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  r     rs1,
    input  csr_t op,
    input  word  in,
    output word  old,
    output word  value
);

    word value_q, value_d, old_q, imm;

    assign imm = {27'b0, rs1};

    always_comb begin
        value_d = value_q;
        case (op)
            CSRRW:   value_d = in;
            CSRRS:   value_d = value_q | in;
            CSRRC:   value_d = value_q & ~in;
            CSRRWI:  value_d = imm;
            CSRRSI:  value_d = value_q | imm;
            CSRRCI:  value_d = value_q & ~imm;
            default: value_d = value_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= DefaultValue;
            old_q   <= '0;
        end else if (en) begin
            value_q <= value_d;
            old_q   <= value_q;
        end
    end

    assign old   = old_q;
    assign value = value_q;

endmodule

// File: rtl/csr_timer.sv
// CSR-mapped periodic timer: prescaled tick counter with a one-cycle match interrupt.
// Define CSR_TIMER_ONESHOT_EN to halt after the first match until the next write.
module csr_timer
    import decoder_pkg::*;
    import timer_pkg::*;
#(
    parameter word         DefaultValue  = '0,
    parameter int unsigned PrescalerBits = PrescalerBitsDefault
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  r     rs1,
    input  csr_t op,
    input  word  in,
    output word  old,
    output word  count,
    output logic interrupt
);

    localparam int unsigned CmpW = 32 - PrescalerBits;
    localparam int unsigned PreW = 2 ** PrescalerBits;

    word                      cfg;
    logic [PrescalerBits-1:0] presc_exp;
    logic [CmpW-1:0]          compare;
    logic [PreW-1:0]          presc_q, presc_d, presc_top;
    logic [CmpW-1:0]          count_q, count_d;
    logic                     irq_q, irq_d;
    logic                     wr, tick, running, match;

    csr #(
        .DefaultValue(DefaultValue)
    ) u_cfg (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .rs1  (rs1),
        .op   (op),
        .in   (in),
        .old  (old),
        .value(cfg)
    );

    assign presc_exp = cfg[PrescalerBits-1:0];
    assign compare   = cfg[31:PrescalerBits];
    assign wr        = en && is_csr_write(op, in, rs1);
    assign presc_top = (PreW'(1) << presc_exp) - PreW'(1);
    assign tick      = (presc_q == presc_top);

`ifdef CSR_TIMER_ONESHOT_EN
    logic halted_q, halted_d;

    always_comb halted_d = wr ? 1'b0 : (halted_q | (tick & match));

    always_ff @(posedge clk) begin
        if (reset) halted_q <= 1'b0;
        else       halted_q <= halted_d;
    end
`else
    logic halted_q;
    assign halted_q = 1'b0;
`endif

    assign running = (compare != '0) && !halted_q;
    assign match   = running && (count_q == compare - CmpW'(1));

    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        irq_d   = 1'b0;
        if (wr) begin
            presc_d = '0;
            count_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PreW'(1);
            if (running && tick) begin
                if (match) begin
                    count_d = '0;
                    irq_d   = 1'b1;
                end else begin
                    count_d = count_q + CmpW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            count_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            irq_q   <= irq_d;
        end
    end

    assign count     = {{PrescalerBits{1'b0}}, count_q};
    assign interrupt = irq_q;

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: access table, hand-written corner sequences and a
// random run compared against a time-since-write model of the timer.
module tb_csr_timer;
    import decoder_pkg::*;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic reset, en, interrupt;
    r     rs1;
    csr_t op;
    word  in, old, count;

    int checks = 0;
    int errors = 0;

    word             m_cfg, m_old;
    longint unsigned m_t;

    csr_timer dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rs1      (rs1),
        .op       (op),
        .in       (in),
        .old      (old),
        .count    (count),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the timer is fully described by cfg and the cycles elapsed since the last restart.
    task automatic model_edge(input logic rst_v, input logic en_v, input csr_t op_v,
                              input word in_v, input r rs1_v);
        word imm;
        logic restart;
        imm = {27'b0, rs1_v};
        restart = 1'b0;
        if (rst_v) begin
            m_cfg = '0;
            m_old = '0;
            m_t   = 0;
        end else begin
            if (en_v) begin
                m_old = m_cfg;
                case (op_v)
                    CSRRW:  begin m_cfg = in_v;           restart = 1'b1;        end
                    CSRRWI: begin m_cfg = imm;            restart = 1'b1;        end
                    CSRRS:  begin m_cfg = m_cfg | in_v;   restart = (in_v != 0); end
                    CSRRC:  begin m_cfg = m_cfg & ~in_v;  restart = (in_v != 0); end
                    CSRRSI: begin m_cfg = m_cfg | imm;    restart = (imm != 0);  end
                    CSRRCI: begin m_cfg = m_cfg & ~imm;   restart = (imm != 0);  end
                    default: ;
                endcase
            end
            m_t = restart ? 0 : m_t + 1;
        end
    endtask

    task automatic model_out(output longint unsigned c, output logic irq);
        longint unsigned cmp, p, period;
        cmp = longint'(m_cfg >> 4);
        p   = longint'(m_cfg & 32'hF);
        period = cmp << p;
        c   = 0;
        irq = 1'b0;
        if (cmp != 0) begin
`ifdef CSR_TIMER_ONESHOT_EN
            c   = (m_t < period) ? (m_t >> p) % cmp : 0;
            irq = (m_t == period);
`else
            c   = (m_t >> p) % cmp;
            irq = (m_t != 0) && (m_t % period == 0);
`endif
        end
    endtask

    task automatic step(input logic rst_v, input logic en_v, input csr_t op_v,
                        input word in_v, input r rs1_v);
        longint unsigned c;
        logic irq;
        reset = rst_v;
        en    = en_v;
        op    = op_v;
        in    = in_v;
        rs1   = rs1_v;
        @(posedge clk);
        model_edge(rst_v, en_v, op_v, in_v, rs1_v);
        #1;
        model_out(c, irq);
        check("old", old, m_old);
        check("count", count, c);
        check("interrupt", interrupt, irq);
        reset = 1'b0;
        en    = 1'b0;
        op    = CSR_NONE;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, CSR_NONE, '0, '0);
    endtask

    task automatic wr(input word v);
        step(1'b0, 1'b1, CSRRW, v, '0);
    endtask

    typedef struct {
        csr_t op;
        word  in_v;
        r     rs1_v;
        word  exp_old;
    } acc_t;

    acc_t tbl[9];
    int   pulses[$];
    int   exp_pulses[$];
    csr_t ops[7];
    timer_cfg_t tc;

    task automatic collect(input int n);
        pulses = {};
        for (int i = 1; i <= n; i++) begin
            idle();
            if (interrupt) pulses.push_back(i);
        end
    endtask

    task automatic check_pulses(input string name);
        check({name, "_n"}, pulses.size(), exp_pulses.size());
        for (int i = 0; i < exp_pulses.size() && i < pulses.size(); i++)
            check({name, "_at"}, pulses[i], exp_pulses[i]);
    endtask

    initial begin
        ops = '{CSR_NONE, CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI};
        tbl[0] = '{CSRRW,    32'h3F,   5'h00, 32'h00};
        tbl[1] = '{CSRRCI,   32'h0,    5'h1F, 32'h3F};
        tbl[2] = '{CSRRSI,   32'h0,    5'h05, 32'h20};
        tbl[3] = '{CSRRS,    32'h100,  5'h00, 32'h25};
        tbl[4] = '{CSRRC,    32'h101,  5'h00, 32'h125};
        tbl[5] = '{CSRRWI,   32'h0,    5'h13, 32'h24};
        tbl[6] = '{CSR_NONE, 32'hFFFF, 5'h1F, 32'h13};
        tbl[7] = '{CSRRW,    32'h0,    5'h00, 32'h13};
        tbl[8] = '{CSRRS,    32'h0,    5'h00, 32'h00};

        m_cfg = '0;
        m_old = '0;
        m_t   = 0;
        step(1'b1, 1'b0, CSR_NONE, '0, '0);
        step(1'b1, 1'b0, CSR_NONE, '0, '0);
        for (int i = 0; i < 20; i++) idle();

        // p=0, C=3
        tc = '{compare: 28'd3, prescaler: 4'd0};
        wr(word'(tc));
        collect(10);
`ifdef CSR_TIMER_ONESHOT_EN
        exp_pulses = {3};
`else
        exp_pulses = {3, 6, 9};
`endif
        check_pulses("p0c3");

        // p=2, C=2; zero-mask set must not restart
        wr(32'h22);
        collect(16);
`ifdef CSR_TIMER_ONESHOT_EN
        exp_pulses = {8};
`else
        exp_pulses = {8, 16};
`endif
        check_pulses("p2c2");
        step(1'b0, 1'b1, CSRRS, 32'h0, '0);
        check("rs0_old", old, 32'h22);
        for (int i = 0; i < 6; i++) idle();
        idle();
`ifdef CSR_TIMER_ONESHOT_EN
        check("rs0_cont", interrupt, 1'b0);
`else
        check("rs0_cont", interrupt, 1'b1);
`endif

        // write on the edge of a scheduled match
        wr(32'h30);
        idle();
        idle();
        wr(32'h30);
        check("wr_prio_irq", interrupt, 1'b0);
        check("wr_prio_cnt", count, 0);
        collect(3);
        exp_pulses = {3};
        check_pulses("wr_prio");

        // oneshot re-arm / periodic continuation
        wr(32'h20);
        collect(6);
`ifdef CSR_TIMER_ONESHOT_EN
        exp_pulses = {2};
`else
        exp_pulses = {2, 4, 6};
`endif
        check_pulses("p0c2");
        wr(32'h20);
        collect(2);
        exp_pulses = {2};
        check_pulses("rearm");

        // reset mid-count
        wr(32'h50);
        idle();
        idle();
        step(1'b1, 1'b0, CSR_NONE, '0, '0);
        check("rst_cnt", count, 0);
        check("rst_old", old, 0);
        for (int i = 0; i < 8; i++) idle();

        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, tbl[i].op, tbl[i].in_v, tbl[i].rs1_v);
            check("tbl_old", old, tbl[i].exp_old);
        end
        for (int i = 0; i < 5; i++) idle();
        check("disabled_cnt", count, 0);

        for (int i = 0; i < 600; i++) begin
            logic rst_v, en_v;
            word  v;
            rst_v = ($urandom_range(0, 99) == 0);
            en_v  = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) != 0)
                v = ($urandom_range(0, 6) << 4) | $urandom_range(0, 3);
            else
                v = $urandom();
            step(rst_v, en_v, ops[$urandom_range(0, 6)], v, r'($urandom()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
